// File: rtl/control_sequencer.sv
// control_sequencer: Moore control-step sequencer for the SRC datapath.
// It steps fetch T0-T2 and execute T3-T7 for load/store/ALU opcodes.
// Outputs are decoded only from registered state, so they are held
// constant while a memory handshake stalls a step.
// Ports:
//   clk, reset (sync, active-high), IR[31:0], mem_rdy
//   register-file selects and strobes: Gra Grb Grc Rin Rout BAout
//   PC, MAR, MDR, IR, Y and Z strobes, Cout, Read, Write
//   alu_op[OPCODE_W-1:0], run, illegal
// Build option: SINGLE_STEP_EN adds input step and a WAIT_STEP state
// that is entered ahead of every T0.
module control_sequencer #(
    parameter int OPCODE_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         IR,
    input  logic                mem_rdy,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                Write,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Cout,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                run,
    output logic                illegal
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;
`ifdef SINGLE_STEP_EN
    localparam logic [3:0] S_WAIT = 4'd10;
    localparam logic [3:0] S_ENTRY = S_WAIT;
`else
    localparam logic [3:0] S_ENTRY = S_T0;
`endif

    localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(26);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(27);

    function automatic logic is_rr(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_imm(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_mem(input logic [OPCODE_W-1:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    logic [3:0]          state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                ill_q, ill_d;
    logic [OPCODE_W-1:0] opc;
    logic                supported;

    assign opc       = IR[31 -: OPCODE_W];
    assign supported = is_rr(opc) || is_imm(opc) || is_mem(opc);

    logic unused_ir;
    assign unused_ir = ^IR[31-OPCODE_W:0];

    always_comb begin
        state_d = state_q;
        // Opcode is captured as IR is decoded so execute steps decode
        // from registered state only.
        op_d    = (state_q == S_T2) ? opc : op_q;
        ill_d   = (state_q == S_T0) ? 1'b0 : ill_q;
        case (state_q)
            S_RST: state_d = S_ENTRY;
            S_T0:  state_d = S_T1;
            S_T1:  if (mem_rdy) state_d = S_T2;
            S_T2: begin
                if (opc == OP_NOP) begin
                    state_d = S_ENTRY;
                end else if (opc == OP_HALT) begin
                    state_d = S_HALT;
                end else if (supported) begin
                    state_d = S_T3;
                end else begin
                    state_d = S_ENTRY;
                    ill_d   = 1'b1;
                end
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: state_d = (op_q == OP_LD || op_q == OP_ST) ? S_T6 : S_ENTRY;
            S_T6: if (op_q == OP_ST || mem_rdy) state_d = S_T7;
            S_T7: if (op_q != OP_ST || mem_rdy) state_d = S_ENTRY;
            S_HALT: state_d = S_HALT;
`ifdef SINGLE_STEP_EN
            S_WAIT: if (step) state_d = S_T0;
`endif
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            op_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        Read = 1'b0; Write = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
        alu_op  = '0;
        run     = (state_q != S_RST) && (state_q != S_HALT);
        illegal = (state_q == S_T0) && ill_q;
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Grb = 1'b1; Yin = 1'b1;
                // Loads/stores and ldi use the base-address path so R0 reads as 0.
                if (is_mem(op_q)) BAout = 1'b1;
                else Rout = 1'b1;
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_rr(op_q)) begin
                    Grc = 1'b1; Rout = 1'b1; alu_op = op_q;
                end else begin
                    Cout = 1'b1;
                    if (op_q == OP_ANDI) alu_op = OP_AND;
                    else if (op_q == OP_ORI) alu_op = OP_OR;
                    else alu_op = OP_ADD;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_q == OP_LD || op_q == OP_ST) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (op_q == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                if (op_q == OP_ST) begin
                    Write = 1'b1;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction sequences checked every cycle
// against a per-instruction list of expected control words.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mem_rdy = 1'b0;
    logic [31:0] IR = '0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC;
    logic MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout;
    logic [4:0] alu_op;
    logic run, illegal;

    control_sequencer #(.OPCODE_W(5)) dut (
        .clk(clk), .reset(reset), .IR(IR), .mem_rdy(mem_rdy),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
        .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Cout(Cout), .alu_op(alu_op), .run(run),
        .illegal(illegal)
    );

    localparam logic [25:0] COUT   = 26'd1 << 0;
    localparam logic [25:0] ZLOW   = 26'd1 << 1;
    localparam logic [25:0] ZIN    = 26'd1 << 2;
    localparam logic [25:0] YIN    = 26'd1 << 3;
    localparam logic [25:0] IRIN   = 26'd1 << 4;
    localparam logic [25:0] WRITE  = 26'd1 << 5;
    localparam logic [25:0] READ   = 26'd1 << 6;
    localparam logic [25:0] MDROUT = 26'd1 << 7;
    localparam logic [25:0] MDRIN  = 26'd1 << 8;
    localparam logic [25:0] MARIN  = 26'd1 << 9;
    localparam logic [25:0] INCPC  = 26'd1 << 10;
    localparam logic [25:0] PCIN   = 26'd1 << 11;
    localparam logic [25:0] PCOUT  = 26'd1 << 12;
    localparam logic [25:0] BAOUT  = 26'd1 << 13;
    localparam logic [25:0] ROUT   = 26'd1 << 14;
    localparam logic [25:0] RIN    = 26'd1 << 15;
    localparam logic [25:0] GRC    = 26'd1 << 16;
    localparam logic [25:0] GRB    = 26'd1 << 17;
    localparam logic [25:0] GRA    = 26'd1 << 18;
    localparam logic [25:0] RUN    = 26'd1 << 24;
    localparam logic [25:0] ILL    = 26'd1 << 25;

    logic [25:0] dut_vec;
    assign dut_vec = {illegal, run, alu_op, Gra, Grb, Grc, Rin, Rout,
                      BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                      Read, Write, IRin, Yin, Zin, Zlowout, Cout};

    logic [25:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_run = 0, rd_max = 0, wr_run = 0, wr_max = 0;
    int wr_cnt = 0, ill_cnt = 0;
    bit pend_ill = 1'b0;

    function automatic logic [25:0] alu(input int op);
        return 26'(op) << 19;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // The single compare process: every queued cycle is checked.
    always @(negedge clk) begin
        logic [25:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL ctrl_word cyc=%0d got=%h exp=%h", cyc, dut_vec, e);
            end
            checks++;
            if ((Rin && (Rout || BAout)) || ($countones({Gra, Grb, Grc}) > 1)
                || (Read && Write)) begin
                errors++;
                $display("FAIL exclusivity cyc=%0d got=%h exp=no_overlap", cyc, dut_vec);
            end
        end
        if (Read === 1'b1) rd_run++; else rd_run = 0;
        if (rd_run > rd_max) rd_max = rd_run;
        if (Write === 1'b1) begin wr_run++; wr_cnt++; end else wr_run = 0;
        if (wr_run > wr_max) wr_max = wr_run;
        if (illegal === 1'b1) ill_cnt++;
    end

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Queue the expected word for the current cycle, then drive inputs.
    task automatic emit(input logic [25:0] v, input logic mr, input logic rs = 1'b0);
        exp_q.push_back(v);
        mem_rdy = mr;
        reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [25:0] cur, input int n);
        emit(cur, 1'b1, 1'b1);
        repeat (n - 1) emit('0, rnd(), 1'b1);
        emit('0, rnd(), 1'b0);
        pend_ill = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] ir, input int t1s,
                            input int ms, input int abort, output int n);
        int op;
        op = int'(ir[31:27]);
        IR = ir;
        n = 0;
`ifdef SINGLE_STEP_EN
        emit(RUN, rnd());
`endif
        emit(PCOUT | MARIN | INCPC | ZIN | RUN | (pend_ill ? ILL : 26'd0), rnd());
        pend_ill = 1'b0;
        n++;
        repeat (t1s) begin emit(ZLOW | PCIN | READ | MDRIN | RUN, 1'b0); n++; end
        emit(ZLOW | PCIN | READ | MDRIN | RUN, 1'b1); n++;
        emit(MDROUT | IRIN | RUN, rnd()); n++;
        if (op == 26 || op == 27) begin
        end else if (op >= 3 && op <= 6) begin
            emit(GRB | ROUT | YIN | RUN, rnd());
            emit(GRC | ROUT | ZIN | RUN | alu(op), rnd());
            emit(ZLOW | GRA | RIN | RUN, rnd());
            n += 3;
        end else if (op >= 12 && op <= 14) begin
            emit(GRB | ROUT | YIN | RUN, rnd());
            emit(COUT | ZIN | RUN | alu(op == 12 ? 3 : (op == 13 ? 5 : 6)), rnd());
            emit(ZLOW | GRA | RIN | RUN, rnd());
            n += 3;
        end else if (op <= 2) begin
            emit(GRB | BAOUT | YIN | RUN, rnd());
            emit(COUT | ZIN | RUN | alu(3), rnd());
            n += 2;
            if (op == 1) begin
                emit(ZLOW | GRA | RIN | RUN, rnd()); n++;
            end else begin
                emit(ZLOW | MARIN | RUN, rnd()); n++;
                if (op == 0) begin
                    if (abort > 0) begin
                        repeat (abort) emit(READ | MDRIN | RUN, 1'b0);
                        n += abort;
                        return;
                    end
                    repeat (ms) emit(READ | MDRIN | RUN, 1'b0);
                    emit(READ | MDRIN | RUN, 1'b1);
                    emit(MDROUT | GRA | RIN | RUN, rnd());
                    n += ms + 2;
                end else begin
                    emit(GRA | ROUT | MDRIN | RUN, rnd());
                    repeat (ms) emit(WRITE | RUN, 1'b0);
                    emit(WRITE | RUN, 1'b1);
                    n += ms + 2;
                end
            end
        end else begin
            pend_ill = 1'b1;
        end
    endtask

    initial begin
        int n;
        @(posedge clk);
        #1;
        emit('0, rnd(), 1'b1);
        emit('0, rnd(), 1'b0);
`ifndef SINGLE_STEP_EN
        lit("rst_T0_strobes", int'({PCout, MARin, IncPC, Zin, run}), 31);
`endif
        do_instr(32'h18918000, 0, 0, 0, n);
        lit("add_cycles", n, 6);
        do_instr(32'h00440010, 0, 3, 0, n);
        lit("ld_cycles", n, 11);
        lit("ld_read_hold", rd_max, 4);
        do_instr(32'h10400020, 0, 2, 0, n);
        lit("st_cycles", n, 10);
        lit("st_write_hold", wr_max, 3);
        do_instr(32'h20918000, 2, 0, 0, n);
        do_instr(32'h28918000, 0, 0, 0, n);
        do_instr(32'h30918000, 1, 0, 0, n);
        do_instr(32'h60840005, 0, 0, 0, n);
        do_instr(32'h68840005, 0, 0, 0, n);
        do_instr(32'h70840005, 0, 0, 0, n);
        do_instr(32'h08400007, 0, 0, 0, n);
        lit("ldi_cycles", n, 6);
        do_instr(32'hF8000000, 0, 0, 0, n);
        do_instr(32'hD0000000, 0, 0, 0, n);
        lit("nop_cycles", n, 3);
        lit("illegal_pulses", ill_cnt, 1);
        do_instr(32'hD8000000, 0, 0, 0, n);
        repeat (20) emit('0, rnd());
        lit("halt_run", int'(run), 0);
        do_reset('0, 2);
        do_instr(32'h00440010, 0, 0, 3, n);
        do_reset(READ | MDRIN | RUN, 1);
        do_instr(32'h18918000, 0, 0, 0, n);
        do_instr(32'h00440010, 0, 0, 0, n);
        @(negedge clk);
        #1;
        lit("write_total", wr_cnt, 3);
        lit("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
